// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and iteration count shared by the HI/LO multiply/divide unit.
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int ITER_COUNT = 32;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_ITER,
        ST_DIV_ITER,
        ST_SIGN_FIX,
        ST_DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 division step on {rem, quo}.
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);
    logic [32:0] sh;
    logic [32:0] diff;
    logic        ge;
    assign sh       = {rem, quo[31]};
    assign diff     = sh - {1'b0, divisor};
    assign ge       = sh >= {1'b0, divisor};
    assign rem_next = ge ? diff[31:0] : sh[31:0];
    assign quo_next = {quo[30:0], ge};
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO write port.
// Define MULDIV_ITER_MUL_EN for a 32-cycle shift-add multiply instead of a single-cycle multiplier.
module hilo_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        hl_write_enable,
    output logic [63:0] hl_data
);
    state_t      state;
    logic [31:0] rem, quo, dvs;
    logic [31:0] rem_nx, quo_nx;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod, mul_res, div_res;
    logic [5:0]  cnt;
    logic        div_op, neg_res, neg_rem, div_zero;
    logic        is_div, sgn, accept, last;

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign sgn    = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag  = (sgn && src_a[31]) ? -src_a : src_a;
    assign b_mag  = (sgn && src_b[31]) ? -src_b : src_b;
    assign accept = start && !cancel && (state == ST_IDLE || state == ST_DONE);
    assign last   = cnt == 6'(ITER_COUNT - 1);
    assign hl_write_enable = (state == ST_DONE) && !cancel;

    div_step u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

`ifdef MULDIV_ITER_MUL_EN
    // Accumulator lives in {rem, quo}; multiplier bits shift out of quo as product bits shift in.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : 33'd0);
    assign prod    = {rem, quo};
`else
    assign prod    = {32'd0, dvs} * {32'd0, quo};
`endif

    // Divide by zero leaves rem = |a|, so the remainder fix restores the raw dividend.
    assign mul_res = neg_res ? -prod : prod;
    assign div_res = {neg_rem ? -rem : rem, div_zero ? 32'hFFFF_FFFF : (neg_res ? -quo : quo)};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            hl_data  <= 64'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dvs      <= 32'd0;
            cnt      <= 6'd0;
            div_op   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (cancel && state != ST_IDLE) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else if (accept) begin
`ifdef MULDIV_ITER_MUL_EN
            state    <= is_div ? ST_DIV_ITER : ST_MUL_ITER;
`else
            state    <= is_div ? ST_DIV_ITER : ST_SIGN_FIX;
`endif
            busy     <= 1'b1;
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quo      <= is_div ? a_mag : b_mag;
            dvs      <= is_div ? b_mag : a_mag;
            div_op   <= is_div;
            neg_res  <= sgn && (src_a[31] ^ src_b[31]);
            neg_rem  <= sgn && src_a[31];
            div_zero <= is_div && (src_b == 32'd0);
        end else begin
            case (state)
                ST_DIV_ITER: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    cnt   <= cnt + 6'd1;
                    state <= last ? ST_SIGN_FIX : ST_DIV_ITER;
                end
`ifdef MULDIV_ITER_MUL_EN
                ST_MUL_ITER: begin
                    rem   <= mul_sum[32:1];
                    quo   <= {mul_sum[0], quo[31:1]};
                    cnt   <= cnt + 6'd1;
                    state <= last ? ST_SIGN_FIX : ST_MUL_ITER;
                end
`endif
                ST_SIGN_FIX: begin
                    hl_data <= div_op ? div_res : mul_res;
                    busy    <= 1'b0;
                    state   <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit that produces the 64-bit HI/LO result for MULT, MULTU, DIV and DIVU. It sits in the EX/WB path and drives the register file's HI/LO write port (`hl_write_enable_from_wb`, `hl_data`). It stalls the pipeline through `busy` while an operation is in flight, and it honours exception flushes through `cancel`.

## Interface
- No parameters; the datapath is fixed at 32-bit operands and a 64-bit result.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-low; the block is in reset while `rst` is 0 at a rising edge.
- `start` in 1: request to begin an operation; sampled only when `busy`=0.
- `op` in 2: operation select, sampled with `start`: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a` in 32: multiplicand or dividend (rs); sampled with `start`.
- `src_b` in 32: multiplier or divisor (rt); sampled with `start`.
- `cancel` in 1: flush; abort the operation and suppress its write.
- `busy` out 1: operation in flight; the pipeline holds EX while this is high.
- `hl_write_enable` out 1: one-cycle HI/LO write pulse; connects to `hl_write_enable_from_wb`.
- `hl_data` out 64: result; bits [63:32] are HI and bits [31:0] are LO. Held stable after the pulse until the next result.

## Operation
- **States:** IDLE, MUL_ITER, DIV_ITER, SIGN_FIX, DONE.
- **Accept:** when `start`=1, `cancel`=0 and the state is IDLE or DONE, the block:
  - latches |a| and |b| (absolute values for signed ops, raw values for unsigned ops);
  - latches the result sign (a[31]^b[31]) and the remainder sign (a[31]), both for signed ops only;
  - moves to DIV_ITER or MUL_ITER and clears the 6-bit iteration counter.
- **DIV_ITER:** restoring radix-2 division, one quotient bit per cycle.
  - Each cycle: shift {rem, quo} left by 1; if rem ≥ divisor, subtract the divisor and set the quotient LSB.
  - After 32 iterations, go to SIGN_FIX.
- **MUL_ITER:** shift-add, one multiplier bit per cycle; after 32 iterations, go to SIGN_FIX.
- **SIGN_FIX:**
  - Multiply: negate the 64-bit product if the result sign is set.
  - Divide: negate the quotient if the result sign is set; negate the remainder if the remainder sign is set.
  - Write {HI,LO} into `hl_data`: {product} for multiply, {remainder, quotient} for divide.
  - Go to DONE.
- **DONE:**
  - `hl_write_enable` = ~`cancel` for this one cycle.
  - Next state: IDLE, or a new accept if `start`=1.
- **Divide by zero:** `hl_data` = {src_a, 32'hFFFFFFFF} for both DIV and DIVU; the sign fix is bypassed. The iteration still runs, so latency is unchanged.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives HI=0, LO=0x80000000. This is the natural result of 32-bit truncation and needs no special case.
- **Cancel:** in any non-IDLE state, the next state is IDLE, there is no write pulse, and `hl_data` keeps its old value. If `cancel` and `start` are high in the same cycle, `cancel` wins and the start is dropped.
- **Reset:** applies from any state, including mid-operation. The next state is IDLE, with `busy`=0, `hl_write_enable`=0, `hl_data`=0, and the counter and working registers cleared.

## Timing
- Cycle 0 is the cycle in which `start` is sampled.
- **DIV/DIVU, and multiply with iterative multiply built in:**
  - cycles 1–32: DIV_ITER or MUL_ITER;
  - cycle 33: SIGN_FIX;
  - cycle 34: DONE, with `hl_write_enable`=1.
- **Multiply without iterative multiply:**
  - cycle 1: SIGN_FIX (single-cycle 32×32 product);
  - cycle 2: DONE.
- `busy`: high from cycle 1 through SIGN_FIX; low in DONE and IDLE.
- `hl_data`: valid from the DONE cycle onward.
- **Back-to-back:** a `start` in the DONE cycle is accepted, so operations can run with no idle bubble.
- **Outputs:** all outputs are registered except `hl_write_enable`, which is the DONE state gated by `cancel`.

## Configuration
- **`MULDIV_ITER_MUL_EN` defined:** multiply goes through MUL_ITER (32 cycles); no hardware multiplier is inferred.
- **`MULDIV_ITER_MUL_EN` undefined:** multiply skips MUL_ITER, and SIGN_FIX uses a combinational 32×32 unsigned product of the latched magnitudes. Multiply latency is 2 cycles; divide is unaffected.

## Structure
- **Shared package `muldiv_pkg`:**
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encoding constants;
  - ITER_COUNT = 32.
- **Sub-module `div_step`:** combinational; one restoring step taking {rem, quo, divisor} and producing the next {rem, quo}. It is instantiated once in `hilo_muldiv`.
- **Kept inline in `hilo_muldiv`:** the FSM, counter, sign logic and multiplier.

## Test plan
- DIVU 100/7: `hl_data` = {32'd2, 32'd14}; `hl_write_enable` pulses exactly once, 34 cycles after `start`; `busy` is high for cycles 1–33.
- DIV −7/2 (0xFFFFFFF9 / 2): HI=0xFFFFFFFF (−1), LO=0xFFFFFFFD (−3). DIV 0x80000000 / 0xFFFFFFFF: HI=0, LO=0x80000000.
- DIVU 5/0: `hl_data` = {32'd5, 32'hFFFFFFFF}; latency is still 34 cycles.
- MULT 0xFFFFFFFF × 3: `hl_data` = 64'hFFFFFFFF_FFFFFFFD. MULTU with the same operands: 64'h00000002_FFFFFFFD. Check latency of 34 with the macro defined and 2 without.
- `cancel` in cycle 10 of a DIV: no write pulse, `busy`=0 from cycle 11, old `hl_data` retained. `start` with `cancel` in the same cycle: no operation starts.
- `rst` low in cycle 5 of a DIV: the next cycle shows `busy`=0 and `hl_data`=0. A back-to-back `start` in the DONE cycle produces a second pulse 34 cycles later.
